// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the word-indexed data RAM path: access sizes, LSU states, latched request.
// No logic; constants, types and one alignment helper only.
// Imported by the LSU top, its lane unit and the core/LSU interface.
package riscv_mem_pkg;

    localparam logic [1:0] SIZE_BYTE     = 2'b00;
    localparam logic [1:0] SIZE_HALF     = 2'b01;
    localparam logic [1:0] SIZE_WORD     = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL  = 2'b11;

    // The RAM side is always word-wide.
    localparam logic [1:0] MEM_SIZE_WORD = SIZE_WORD;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        STORE,
        RESP
    } lsu_state_t;

    // Request fields still needed after the accept edge.
    typedef struct packed {
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  addr_lo;
        logic [31:0] wdata;
    } lsu_req_t;

    // True when size/address cannot be served as a single aligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SIZE_ILLEGAL) ||
               ((size == SIZE_HALF) && addr_lo[0]) ||
               ((size == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/riscv_lsu_word_initiator_if.sv
// Core <-> LSU request/response bundle; valid/ready on both directions.
// Ports: req_valid/ready/write/size/unsigned/addr/wdata, resp_valid/ready/rdata/misalign/fault.
// master = core memory stage, slave = LSU.
interface riscv_lsu_word_initiator_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        resp_fault;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_misalign, resp_fault
    );

endinterface

// File: rtl/riscv_lane_unit.sv
// Byte/half lane handling: load extract + sign/zero extend, and store merge into a RAM word.
// Latency: purely combinational.
// Backpressure: none; ports: word, wdata, size, uns, addr_lo in; load_data, store_word out.
module riscv_lane_unit
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  addr_lo,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [4:0]  byte_shift;

    always_comb begin
        byte_shift = {addr_lo, 3'b000};
        byte_lane  = word[byte_shift +: 8];
        half_lane  = addr_lo[1] ? word[31:16] : word[15:0];

        case (size)
            SIZE_BYTE: load_data = uns ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SIZE_HALF: load_data = uns ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default:   load_data = word;
        endcase

        store_word = word;
        case (size)
            SIZE_BYTE: store_word[byte_shift +: 8] = wdata[7:0];
            SIZE_HALF: begin
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            default:   store_word = wdata;
        endcase
    end

endmodule

// File: rtl/riscv_lsu_word_initiator.sv
// Load/store initiator from the core memory stage to a word-indexed RAM; sub-word stores become RMW.
// Latency accept->resp_valid: error 1 edge, load 2, word store 2, byte/half store 3.
// Backpressure: req_ready only in IDLE; resp_ready low parks in RESP with all RAM strobes low.
// Ports: clk, rst_n (sync, active-low), core (slave modport), mem_read/write/size/unsigned/addr/wdata/rdata.
module riscv_lsu_word_initiator
    import riscv_mem_pkg::*;
#(
    parameter int MEM_WORDS = 1032
) (
    input  logic        clk,
    input  logic        rst_n,
    riscv_lsu_word_initiator_if.slave core,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    lsu_req_t    rq;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        resp_fault;

    logic        misalign;
    logic        out_of_range;
    logic [31:0] word_idx;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    assign mem_size           = MEM_SIZE_WORD;
    assign mem_unsigned       = 1'b0;

    assign core.req_ready     = (state == IDLE);
    assign core.resp_valid    = resp_valid;
    assign core.resp_rdata    = resp_rdata;
    assign core.resp_misalign = resp_misalign;
    assign core.resp_fault    = resp_fault;

    always_comb begin
        word_idx     = {2'b00, core.req_addr[31:2]};
        misalign     = is_misaligned(core.req_size, core.req_addr[1:0]);
        out_of_range = (word_idx >= 32'(MEM_WORDS));
    end

    // RAM read data is combinational, so the lane unit works directly on mem_rdata in LOAD/RMW_RD.
    riscv_lane_unit u_lane (
        .word       (mem_rdata),
        .wdata      (rq.wdata),
        .size       (rq.size),
        .uns        (rq.uns),
        .addr_lo    (rq.addr_lo),
        .load_data  (ld_data),
        .store_word (st_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rq            <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'h0;
            resp_misalign <= 1'b0;
            resp_fault    <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_addr      <= 32'h0;
            mem_wdata     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (core.req_valid) begin
                        rq.size    <= core.req_size;
                        rq.uns     <= core.req_unsigned;
                        rq.addr_lo <= core.req_addr[1:0];
                        rq.wdata   <= core.req_wdata;
                        if (misalign) begin
                            // Misalign wins over range fault when both apply.
                            resp_valid    <= 1'b1;
                            resp_misalign <= 1'b1;
                            state         <= RESP;
                        end else if (out_of_range) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            state      <= RESP;
                        end else begin
                            mem_addr <= word_idx;
                            if (!core.req_write) begin
                                mem_read <= 1'b1;
                                state    <= LOAD;
                            end else if (core.req_size == SIZE_WORD) begin
                                mem_write <= 1'b1;
                                mem_wdata <= core.req_wdata;
                                state     <= STORE;
                            end else begin
                                mem_read <= 1'b1;
                                state    <= RMW_RD;
                            end
                        end
                    end
                end
                LOAD: begin
                    mem_read   <= 1'b0;
                    mem_addr   <= 32'h0;
                    resp_rdata <= ld_data;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_RD: begin
                    // mem_addr is kept so the write lands on the word just read.
                    mem_read  <= 1'b0;
                    mem_write <= 1'b1;
                    mem_wdata <= st_word;
                    state     <= STORE;
                end
                STORE: begin
                    mem_write  <= 1'b0;
                    mem_wdata  <= 32'h0;
                    mem_addr   <= 32'h0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (core.resp_ready) begin
                        resp_valid    <= 1'b0;
                        resp_rdata    <= 32'h0;
                        resp_misalign <= 1'b0;
                        resp_fault    <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
